// File: rtl/sys_div_arb_if.sv
// Bundle between the requesters and the shared divider sys_div_arb.
// The requester side drives REQ/NUM/DEN and observes GNT/BUSY/DONE/RES.
// With SYS_DIV_ARB_REMAINDER_EN defined the bundle also carries REM.
interface sys_div_arb_if #(
  parameter int NREQ   = 2,
  parameter int NB_NUM = 24,
  parameter int NB_DEN = 12
);
  logic [NREQ-1:0]        REQ;
  logic [NREQ*NB_NUM-1:0] NUM;
  logic [NREQ*NB_DEN-1:0] DEN;
  logic [NREQ-1:0]        GNT;
  logic                   BUSY;
  logic [NREQ-1:0]        DONE;
  logic [NB_NUM-1:0]      RES;
`ifdef SYS_DIV_ARB_REMAINDER_EN
  logic [NB_DEN-1:0]      REM;

  modport master (output REQ, NUM, DEN, input GNT, BUSY, DONE, RES, REM);
  modport slave  (input REQ, NUM, DEN, output GNT, BUSY, DONE, RES, REM);
`else
  modport master (output REQ, NUM, DEN, input GNT, BUSY, DONE, RES);
  modport slave  (input REQ, NUM, DEN, output GNT, BUSY, DONE, RES);
`endif
endinterface

// File: rtl/sys_div_arb.sv
// Shared iterative restoring unsigned divider with round-robin arbitration
// between NREQ requesters in the CLK_VIDEO domain.
// Flow per operation: IDLE (arbitrate) -> LOAD (capture operands) ->
// RUN (NB_NUM shift/subtract steps) -> DONE (strobe owner, release).
// Optional macro SYS_DIV_ARB_REMAINDER_EN adds the REM output.
module sys_div_arb #(
  parameter int NREQ   = 2,
  parameter int NB_NUM = 24,
  parameter int NB_DEN = 12
) (
  input logic          CLK_VIDEO,
  input logic          RESET_N,
  sys_div_arb_if.slave bus
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NB_NUM);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [LW-1:0]     last_q, last_d;
  logic              aband_q, aband_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NB_NUM-1:0] res_q, res_d;
`ifdef SYS_DIV_ARB_REMAINDER_EN
  logic [NB_DEN-1:0] rem_q, rem_d;
`endif

  // Datapath: quotient/numerator shift register, divisor, partial remainder.
  // The stored remainder always fits NB_DEN bits; the NB_DEN+1-bit value
  // only exists transiently after the shift inside div_step.
  logic [NB_NUM-1:0] q_r;
  logic [NB_DEN-1:0] d_r;
  logic [NB_DEN-1:0] r_r;

  logic [NB_NUM-1:0] num_a [NREQ];
  logic [NB_DEN-1:0] den_a [NREQ];

  logic              pick_vld;
  logic [LW-1:0]     pick_idx;
  logic              req_own;

  // One restoring step: shift {R,Q} left, keep R-D when it is non-negative.
  // With D=0 the trial never goes negative, so the quotient fills with ones.
  function automatic logic [NB_DEN+NB_NUM-1:0] div_step(
    input logic [NB_DEN-1:0] r,
    input logic [NB_NUM-1:0] q,
    input logic [NB_DEN-1:0] d
  );
    logic [NB_DEN:0] rs;
    rs = {r, q[NB_NUM-1]};
    if (rs >= {1'b0, d})
      div_step = {NB_DEN'(rs - {1'b0, d}), q[NB_NUM-2:0], 1'b1};
    else
      div_step = {rs[NB_DEN-1:0], q[NB_NUM-2:0], 1'b0};
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign num_a[i] = bus.NUM[i*NB_NUM +: NB_NUM];
    assign den_a[i] = bus.DEN[i*NB_DEN +: NB_DEN];
  end

  assign req_own = bus.REQ[last_q];

  // Round-robin pick: first REQ bit scanning from LAST+1 with wrap.
  always_comb begin
    int          t;
    logic [LW-1:0] ti;
    pick_vld = 1'b0;
    pick_idx = last_q;
    t        = 0;
    ti       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      t = int'(last_q) + k;
      if (t >= NREQ) t = t - NREQ;
      ti = LW'(t);
      if (!pick_vld && bus.REQ[ti]) begin
        pick_vld = 1'b1;
        pick_idx = ti;
      end
    end
  end

  // Next-state and next-output logic of the control FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    last_d  = last_q;
    aband_d = aband_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef SYS_DIV_ARB_REMAINDER_EN
    rem_d   = rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = NREQ'(1) << pick_idx;
          last_d  = pick_idx;
          busy_d  = 1'b1;
          aband_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req_own) aband_d = 1'b1;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!req_own) aband_d = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NB_NUM - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        // A requester that let go of REQ at any point forfeits the result.
        if (req_own && !aband_q) begin
          res_d  = q_r;
`ifdef SYS_DIV_ARB_REMAINDER_EN
          rem_d  = r_r;
`endif
          done_d = gnt_q;
        end
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; asynchronous reset aborts any operation.
  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= LW'(NREQ - 1);
      aband_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
`ifdef SYS_DIV_ARB_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      aband_q <= aband_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
`ifdef SYS_DIV_ARB_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end
  end

  // Divider datapath: operand capture in LOAD, one step per RUN cycle.
  always_ff @(posedge CLK_VIDEO) begin
    if (state_q == S_LOAD) begin
      q_r <= num_a[last_q];
      d_r <= den_a[last_q];
      r_r <= '0;
    end else if (state_q == S_RUN) begin
      {r_r, q_r} <= div_step(r_r, q_r, d_r);
    end
  end

  assign bus.GNT  = gnt_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.RES  = res_q;
`ifdef SYS_DIV_ARB_REMAINDER_EN
  assign bus.REM  = rem_q;
`endif

endmodule
